// File: rtl/regfile_scoreboard.sv
// =============================================================================
// regfile_scoreboard : register file with reservation scoreboard and trigger write
// rev 1.0
// =============================================================================
`default_nettype none

module regfile_scoreboard #(
   parameter int                    ADDRESS_WIDTH = 5,
   parameter int                    DATA_WIDTH    = 32,
   parameter bit                    BYPASS        = 1'b1,
   parameter int                    TRIG_REG      = 5,
   parameter logic [DATA_WIDTH-1:0] TRIG_VALUE    = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDRESS_WIDTH-1:0] AD1_i,
   input  logic [ADDRESS_WIDTH-1:0] AD2_i,
   input  logic [ADDRESS_WIDTH-1:0] AD3_i,
   input  logic                     WE3_i,
   input  logic [DATA_WIDTH-1:0]    WD3_i,
   input  logic                     RSV_i,
   input  logic [ADDRESS_WIDTH-1:0] RSV_AD_i,
   input  logic                     TRIGGER_i,
   output logic [DATA_WIDTH-1:0]    RD1_o,
   output logic [DATA_WIDTH-1:0]    RD2_o,
   output logic                     BUSY1_o,
   output logic                     BUSY2_o,
   output logic [DATA_WIDTH-1:0]    a0_o
);

   localparam int                       NUM_REGS  = 2**ADDRESS_WIDTH;
   localparam int                       A0_REG    = 10;
   localparam logic [ADDRESS_WIDTH-1:0] TRIG_ADDR = ADDRESS_WIDTH'(TRIG_REG);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   pending;
   logic                  trig_sync1;
   logic                  trig_sync2;
   logic                  trig_prev;
   logic [2:0]            sync_valid;
   logic                  trig_pending;
   logic                  trig_edge;
   logic                  trig_req;
   logic                  trig_collide;
   logic                  trig_write;
   logic                  port_write;
   logic                  fwd1;
   logic                  fwd2;

   assign port_write   = WE3_i && (AD3_i != '0);
   // sync_valid marks which stages hold a real post-reset sample, so a level
   // held high across reset is never mistaken for a rising edge
   assign trig_edge    = sync_valid[2] && trig_sync2 && !trig_prev;
   assign trig_req     = trig_pending || trig_edge;
   assign trig_collide = port_write && (AD3_i == TRIG_ADDR);
   assign trig_write   = trig_req && !trig_collide && (TRIG_ADDR != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_sync1   <= 1'b0;
         trig_sync2   <= 1'b0;
         trig_prev    <= 1'b0;
         sync_valid   <= '0;
         trig_pending <= 1'b0;
      end else begin
         trig_sync1   <= TRIGGER_i;
         trig_sync2   <= trig_sync1;
         trig_prev    <= trig_sync2;
         sync_valid   <= {sync_valid[1:0], 1'b1};
         trig_pending <= trig_req && trig_collide;
      end
   end

   // Later assignments win: a reservation overrides a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         pending <= '0;
      end else begin
         if (port_write) begin
            regs[AD3_i]    <= WD3_i;
            pending[AD3_i] <= 1'b0;
         end
         if (trig_write) begin
            regs[TRIG_ADDR] <= TRIG_VALUE;
         end
         if (RSV_i && (RSV_AD_i != '0)) begin
            pending[RSV_AD_i] <= 1'b1;
         end
      end
   end

   assign fwd1 = BYPASS && port_write && (AD3_i == AD1_i);
   assign fwd2 = BYPASS && port_write && (AD3_i == AD2_i);

   always_comb begin
      RD1_o   = '0;
      RD2_o   = '0;
      BUSY1_o = 1'b0;
      BUSY2_o = 1'b0;
      if (rst_n && (AD1_i != '0)) begin
         RD1_o   = fwd1 ? WD3_i : regs[AD1_i];
         BUSY1_o = pending[AD1_i] && !fwd1;
      end
      if (rst_n && (AD2_i != '0)) begin
         RD2_o   = fwd2 ? WD3_i : regs[AD2_i];
         BUSY2_o = pending[AD2_i] && !fwd2;
      end
   end

   assign a0_o = regs[A0_REG];

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// =============================================================================
// tb_regfile_scoreboard : directed and random checks against a reference model
// rev 1.0
// =============================================================================
`default_nettype none

module tb_regfile_scoreboard;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 32;
   localparam int TR = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] ad1, ad2, ad3, rsv_ad;
   logic          we3, rsv, trig;
   logic [DW-1:0] wd3;

   logic [DW-1:0] rd1, rd2, a0;
   logic          busy1, busy2;
   logic [DW-1:0] nb_rd1, nb_rd2, nb_a0;
   logic          nb_busy1, nb_busy2;

   int total = 0;
   int bad   = 0;

   // reference state
   logic [DW-1:0] mem [NR];
   bit            pend [NR];
   bit            tpend;
   bit            hist [$];

   always #5 clk = ~clk;

   regfile_scoreboard u_dut (
      .clk(clk), .rst_n(rst_n), .AD1_i(ad1), .AD2_i(ad2), .AD3_i(ad3),
      .WE3_i(we3), .WD3_i(wd3), .RSV_i(rsv), .RSV_AD_i(rsv_ad),
      .TRIGGER_i(trig), .RD1_o(rd1), .RD2_o(rd2), .BUSY1_o(busy1),
      .BUSY2_o(busy2), .a0_o(a0)
   );

   regfile_scoreboard #(.BYPASS(1'b0)) u_nobyp (
      .clk(clk), .rst_n(rst_n), .AD1_i(ad1), .AD2_i(ad2), .AD3_i(ad3),
      .WE3_i(we3), .WD3_i(wd3), .RSV_i(rsv), .RSV_AD_i(rsv_ad),
      .TRIGGER_i(trig), .RD1_o(nb_rd1), .RD2_o(nb_rd2), .BUSY1_o(nb_busy1),
      .BUSY2_o(nb_busy2), .a0_o(nb_a0)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return '0;
      if (byp && we3 && ad3 == a) return wd3;
      return mem[a];
   endfunction

   function automatic logic m_busy(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return 1'b0;
      return pend[a] && !(byp && we3 && ad3 == a);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         mem[i]  = '0;
         pend[i] = 1'b0;
      end
      tpend = 1'b0;
      hist.delete();
   endtask

   // One rising edge: a trigger edge is seen when the sample taken two edges
   // earlier is 1 and the one before it is 0 (both taken after reset).
   task automatic model_edge();
      int  k;
      bit  tedge;
      hist.push_back(trig);
      k     = hist.size();
      tedge = (k >= 4) && hist[k-3] && !hist[k-4];
      if (tpend || tedge) begin
         if (we3 && ad3 == TR) tpend = 1'b1;
         else begin
            mem[TR] = 32'd1;
            tpend   = 1'b0;
         end
      end
      if (we3 && ad3 != 0) begin
         mem[ad3]  = wd3;
         pend[ad3] = 1'b0;
      end
      if (rsv && rsv_ad != 0) pend[rsv_ad] = 1'b1;
   endtask

   task automatic check_all();
      chk("rd1",      rd1,      m_rd(ad1, 1'b1));
      chk("rd2",      rd2,      m_rd(ad2, 1'b1));
      chk("busy1",    {31'd0, busy1},    {31'd0, m_busy(ad1, 1'b1)});
      chk("busy2",    {31'd0, busy2},    {31'd0, m_busy(ad2, 1'b1)});
      chk("a0",       a0,       mem[10]);
      chk("nb_rd1",   nb_rd1,   m_rd(ad1, 1'b0));
      chk("nb_rd2",   nb_rd2,   m_rd(ad2, 1'b0));
      chk("nb_busy1", {31'd0, nb_busy1}, {31'd0, m_busy(ad1, 1'b0)});
      chk("nb_busy2", {31'd0, nb_busy2}, {31'd0, m_busy(ad2, 1'b0)});
      chk("nb_a0",    nb_a0,    mem[10]);
   endtask

   task automatic drive(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic w, input logic [AW-1:0] a3, input logic [DW-1:0] d,
                        input logic r, input logic [AW-1:0] ra, input logic t);
      ad1 = a1; ad2 = a2; we3 = w; ad3 = a3; wd3 = d; rsv = r; rsv_ad = ra; trig = t;
      #1;
   endtask

   // check current-cycle outputs, take the edge, advance to the next negedge
   task automatic step();
      #1 check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic check_reset_zero();
      chk("rst_rd1",   rd1,              '0);
      chk("rst_rd2",   rd2,              '0);
      chk("rst_busy1", {31'd0, busy1},   '0);
      chk("rst_busy2", {31'd0, busy2},   '0);
      chk("rst_a0",    a0,               '0);
      chk("rst_nb_rd", nb_rd1,           '0);
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(3, 10, 1, 3, 32'hA5A5A5A5, 1, 3, 0);
      check_reset_zero();
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) step();

      // same-cycle forwarding vs stored value
      drive(3, 3, 1, 3, 32'hDEADBEEF, 0, 0, 0);
      chk("bypass_rd1", rd1, 32'hDEADBEEF);
      chk("nobyp_rd1", nb_rd1, 32'h0);
      step();
      drive(3, 0, 0, 0, 0, 0, 0, 0);
      chk("nobyp_after", nb_rd1, 32'hDEADBEEF);
      step();

      // register 0 is hard-wired
      drive(0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
      chk("r0_bypass", rd1, 32'h0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("r0_rd", rd1, 32'h0);
      chk("r0_busy", {31'd0, busy1}, 32'h0);
      step();

      // scoreboard reserve / clear / set-wins
      drive(0, 0, 0, 0, 0, 1, 7, 0);
      step();
      drive(0, 7, 0, 0, 0, 0, 0, 0);
      chk("rsv_busy", {31'd0, busy2}, 32'd1);
      step();
      drive(0, 7, 1, 7, 32'h77, 0, 0, 0);
      chk("wr_cycle_busy", {31'd0, busy2}, 32'd0);
      chk("wr_cycle_nb_busy", {31'd0, nb_busy2}, 32'd1);
      step();
      drive(0, 7, 0, 0, 0, 0, 0, 0);
      chk("cleared_busy", {31'd0, busy2}, 32'd0);
      step();
      drive(0, 7, 1, 7, 32'h78, 1, 7, 0);
      step();
      drive(0, 7, 0, 0, 0, 0, 0, 0);
      chk("set_wins", {31'd0, busy2}, 32'd1);
      step();
      drive(0, 0, 1, 7, 32'h79, 0, 0, 0);
      step();

      // trigger latency, uncontested
      drive(5, 0, 0, 0, 0, 0, 0, 1);
      step();
      step();
      chk("trig_before3", rd1, 32'h0);
      step();
      chk("trig_at3", rd1, 32'd1);
      drive(0, 0, 1, 5, 32'h0, 0, 0, 0);
      step();
      repeat (3) step();

      // trigger contested by a port write on the 3rd edge
      drive(5, 0, 0, 0, 0, 0, 0, 1);
      step();
      step();
      drive(5, 0, 1, 5, 32'h55, 0, 0, 1);
      step();
      drive(5, 0, 0, 0, 0, 0, 0, 1);
      chk("trig_port_first", rd1, 32'h55);
      step();
      chk("trig_deferred", rd1, 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // a0 and mid-cycle reset
      drive(10, 12, 1, 10, 32'h1234, 1, 12, 1);
      chk("a0_before_edge", a0, 32'h0);
      step();
      drive(10, 12, 0, 0, 0, 0, 0, 1);
      chk("a0_after_edge", a0, 32'h1234);
      chk("busy_pre_rst", {31'd0, busy2}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_zero();
      chk("rst_busy_r12", {31'd0, nb_busy2}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      // trigger stays high across reset: no write may follow
      drive(5, 10, 0, 0, 0, 0, 0, 1);
      repeat (6) step();
      chk("no_trig_after_rst", rd1, 32'h0);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic t;
         t = trig;
         if ($urandom_range(0, 4) == 0) t = ~trig;
         drive(AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11)),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 11)), $urandom,
               1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 11)), t);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
